// File: rtl/prog_rom_loader.sv
// Byte-stream program loader: assembles little-endian 48-bit words and writes them sequentially to program memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module prog_rom_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_BYTES = 6
) (
  input  logic                    clk,
  input  logic                    _RESET_SWITCH,
  input  logic                    restart,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  output logic [8*WORD_BYTES-1:0] rom_data,
  output logic                    _rom_we,
  output logic                    _cpu_reset,
  output logic                    done,
  output logic                    error
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, WRITE, CSUM, DONE, ERROR} state_t;

  state_t                  state, state_nxt;
  logic [7:0]              cnt_lo;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic [IDX_W-1:0]        idx;
  logic                    xfer;
  logic [31:0]             hdr_count;
  logic                    count_bad;
  logic                    last_word;
  logic                    idx_last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              csum;
`endif

  assign in_ready  = (state == HDR_LO) || (state == HDR_HI) || (state == DATA) || (state == CSUM);
  assign xfer      = in_valid & in_ready;
  assign hdr_count = {16'd0, in_data, cnt_lo};
  // A zero count encodes a full 2**ADDR_WIDTH image, so only nonzero counts can overflow.
  assign count_bad = (hdr_count != 32'd0) && (hdr_count > (32'd1 << ADDR_WIDTH));
  assign last_word = (rom_addr == last_addr);
  assign idx_last  = (idx == IDX_W'(WORD_BYTES - 1));

  assign _rom_we    = (state != WRITE);
  assign done       = (state == DONE);
  assign error      = (state == ERROR);
  assign _cpu_reset = (state == DONE);

  always_ff @(posedge clk or negedge _RESET_SWITCH) begin
    if (!_RESET_SWITCH) state <= HDR_LO;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = HDR_LO;
    end else begin
      case (state)
        HDR_LO: if (xfer) state_nxt = HDR_HI;
        HDR_HI: if (xfer) state_nxt = count_bad ? ERROR : DATA;
        DATA:   if (xfer && idx_last) state_nxt = WRITE;
        WRITE: begin
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DATA;
          end
        end
        CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (xfer) state_nxt = (in_data == csum) ? DONE : ERROR;
`endif
        end
        DONE:    state_nxt = DONE;
        ERROR:   state_nxt = ERROR;
        default: state_nxt = HDR_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge _RESET_SWITCH) begin
    if (!_RESET_SWITCH) begin
      rom_addr  <= '0;
      rom_data  <= '0;
      cnt_lo    <= '0;
      last_addr <= '0;
      idx       <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else if (restart) begin
      rom_addr <= '0;
      idx      <= '0;
    end else begin
      case (state)
        HDR_LO: if (xfer) cnt_lo <= in_data;
        HDR_HI: begin
          if (xfer) begin
            last_addr <= ADDR_WIDTH'(hdr_count - 32'd1);
            rom_addr  <= '0;
            idx       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        DATA: begin
          if (xfer) begin
            rom_data[8*idx +: 8] <= in_data;
            idx <= idx_last ? '0 : idx + IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
          end
        end
        // The final word never advances the address, so a full image leaves rom_addr on the last slot.
        WRITE: if (!last_word) rom_addr <= rom_addr + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule
